// File: rtl/ff3_pkg.sv
// Shared widths, reset polarity and FSM encoding for the FF3 stage.
// The stage itself is configured with the FF3_REDIRECT_CNT_EN macro, see ff3.sv.
package ff3_pkg;

    localparam logic RST_ENABLE  = 1'b1;

    localparam int REG_ADDR_W  = 7;
    localparam int DATA_W      = 128;
    localparam int UID_W       = 3;
    localparam int ADDR_W      = 32;
    localparam int DRAIN_CNT_W = 3;
    localparam int PERF_CNT_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_REDIRECT = 2'b01,
        ST_DRAIN    = 2'b10
    } ff3_state_t;

    // True when the accepted cycle being processed is the last one of the drain window.
    function automatic logic drain_last(input logic [DRAIN_CNT_W-1:0] cnt);
        return cnt <= DRAIN_CNT_W'(1);
    endfunction

endpackage

// File: rtl/ff3_lane.sv
// One write-back lane of FF3: registers rtaddr/wreg/rt/uid.
// clear kills the write enable, hold freezes the lane, squash captures with the write enable dropped.
module ff3_lane
    import ff3_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  squash,
    input  logic                  clear,
    input  logic [REG_ADDR_W-1:0] src_rtaddr,
    input  logic                  src_wreg,
    input  logic [DATA_W-1:0]     src_rt,
    input  logic [UID_W-1:0]      src_uid,
    output logic [REG_ADDR_W-1:0] rtaddr,
    output logic                  wreg,
    output logic [DATA_W-1:0]     rt,
    output logic [UID_W-1:0]      uid
);

    // Data fields simply hold on clear; only the write enable needs killing.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            rtaddr <= '0;
            wreg   <= 1'b0;
            rt     <= '0;
            uid    <= '0;
        end else if (clear) begin
            wreg   <= 1'b0;
        end else if (!hold) begin
            rtaddr <= src_rtaddr;
            wreg   <= src_wreg & ~squash;
            rt     <= src_rt;
            uid    <= src_uid;
        end
    end

endmodule

// File: rtl/ff3.sv
// FF3 pipeline stage: registers both lanes and the branch fields, and issues the fetch redirect
// followed by a drain window. Optional redirect counter port enabled by FF3_REDIRECT_CNT_EN.
module ff3
    import ff3_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,

    input  logic [REG_ADDR_W-1:0] iff3_rtaddr_e,
    input  logic [REG_ADDR_W-1:0] iff3_rtaddr_o,
    input  logic                  iff3_wreg_e,
    input  logic                  iff3_wreg_o,
    input  logic [DATA_W-1:0]     iff3_rt_e,
    input  logic [DATA_W-1:0]     iff3_rt_o,
    input  logic [UID_W-1:0]      iff3_uid_e,
    input  logic [UID_W-1:0]      iff3_uid_o,
    input  logic [ADDR_W-1:0]     iff3_memory_addr_o,
    input  logic                  iff3_branch_flag,
    input  logic [ADDR_W-1:0]     iff3_branch_target_addr,
    input  logic [ADDR_W-1:0]     iff3_link_addr,
    input  logic                  iff3_is_in_delayslot,

    output logic [REG_ADDR_W-1:0] ff3_rtaddr_e,
    output logic [REG_ADDR_W-1:0] ff3_rtaddr_o,
    output logic                  ff3_wreg_e,
    output logic                  ff3_wreg_o,
    output logic [DATA_W-1:0]     ff3_rt_e,
    output logic [DATA_W-1:0]     ff3_rt_o,
    output logic [UID_W-1:0]      ff3_uid_e,
    output logic [UID_W-1:0]      ff3_uid_o,
    output logic [ADDR_W-1:0]     ff3_memory_addr_o,
    output logic                  ff3_branch_flag,
    output logic [ADDR_W-1:0]     ff3_branch_target_addr,
    output logic [ADDR_W-1:0]     ff3_link_addr,
    output logic                  ff3_is_in_delayslot,

    output logic                  redirect_valid,
    output logic [ADDR_W-1:0]     redirect_pc,
`ifdef FF3_REDIRECT_CNT_EN
    output logic [PERF_CNT_W-1:0] ff3_redirect_cnt,
`endif
    output logic                  ff3_busy
);

    ff3_state_t             state;
    ff3_state_t             state_next;
    logic [DRAIN_CNT_W-1:0] drain_cnt;
    logic [DRAIN_CNT_W-1:0] drain_cnt_next;

    logic accept;
    logic squash;
    logic redirect_entry;

    assign accept         = ~stall & ~flush;
    // Delay-slot instructions survive the drain window untouched.
    assign squash         = (state == ST_DRAIN) & ~iff3_is_in_delayslot;
    assign redirect_entry = accept & (state == ST_IDLE) & iff3_branch_flag;

    ff3_lane u_lane_e (
        .clk        (clk),
        .rst        (rst),
        .hold       (stall),
        .squash     (squash),
        .clear      (flush),
        .src_rtaddr (iff3_rtaddr_e),
        .src_wreg   (iff3_wreg_e),
        .src_rt     (iff3_rt_e),
        .src_uid    (iff3_uid_e),
        .rtaddr     (ff3_rtaddr_e),
        .wreg       (ff3_wreg_e),
        .rt         (ff3_rt_e),
        .uid        (ff3_uid_e)
    );

    ff3_lane u_lane_o (
        .clk        (clk),
        .rst        (rst),
        .hold       (stall),
        .squash     (squash),
        .clear      (flush),
        .src_rtaddr (iff3_rtaddr_o),
        .src_wreg   (iff3_wreg_o),
        .src_rt     (iff3_rt_o),
        .src_uid    (iff3_uid_o),
        .rtaddr     (ff3_rtaddr_o),
        .wreg       (ff3_wreg_o),
        .rt         (ff3_rt_o),
        .uid        (ff3_uid_o)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            ff3_memory_addr_o      <= '0;
            ff3_branch_flag        <= 1'b0;
            ff3_branch_target_addr <= '0;
            ff3_link_addr          <= '0;
            ff3_is_in_delayslot    <= 1'b0;
        end else if (flush) begin
            ff3_branch_flag        <= 1'b0;
        end else if (!stall) begin
            ff3_memory_addr_o      <= iff3_memory_addr_o;
            ff3_branch_flag        <= iff3_branch_flag & ~squash;
            ff3_branch_target_addr <= iff3_branch_target_addr;
            ff3_link_addr          <= iff3_link_addr;
            ff3_is_in_delayslot    <= iff3_is_in_delayslot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
        end
    end

    // REDIRECT lasts exactly one cycle even under stall; only flush can cut it short.
    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        if (flush) begin
            state_next     = ST_IDLE;
            drain_cnt_next = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (redirect_entry) begin
                        state_next = ST_REDIRECT;
                    end
                end
                ST_REDIRECT: begin
                    state_next     = ST_DRAIN;
                    drain_cnt_next = DRAIN_CNT_W'(DRAIN_CYCLES);
                end
                ST_DRAIN: begin
                    if (!stall) begin
                        if (drain_last(drain_cnt)) begin
                            state_next     = ST_IDLE;
                            drain_cnt_next = '0;
                        end else begin
                            drain_cnt_next = drain_cnt - DRAIN_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_next     = ST_IDLE;
                    drain_cnt_next = '0;
                end
            endcase
        end
    end

    assign redirect_valid = (state == ST_REDIRECT) & ~flush;
    assign redirect_pc    = redirect_valid ? ff3_branch_target_addr : '0;
    assign ff3_busy       = (state != ST_IDLE);

`ifdef FF3_REDIRECT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            ff3_redirect_cnt <= '0;
        end else if (redirect_entry) begin
            ff3_redirect_cnt <= ff3_redirect_cnt + PERF_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ff3.sv
// Directed bench for ff3 (DRAIN_CYCLES=2): capture, stall, redirect/drain, delay slots, flush, reset.
// With FF3_REDIRECT_CNT_EN defined it also checks the redirect counter.
module tb_ff3;

    logic         clk;
    logic         rst;
    logic         stall;
    logic         flush;
    logic [6:0]   iff3_rtaddr_e, iff3_rtaddr_o;
    logic         iff3_wreg_e, iff3_wreg_o;
    logic [127:0] iff3_rt_e, iff3_rt_o;
    logic [2:0]   iff3_uid_e, iff3_uid_o;
    logic [31:0]  iff3_memory_addr_o;
    logic         iff3_branch_flag;
    logic [31:0]  iff3_branch_target_addr;
    logic [31:0]  iff3_link_addr;
    logic         iff3_is_in_delayslot;

    logic [6:0]   ff3_rtaddr_e, ff3_rtaddr_o;
    logic         ff3_wreg_e, ff3_wreg_o;
    logic [127:0] ff3_rt_e, ff3_rt_o;
    logic [2:0]   ff3_uid_e, ff3_uid_o;
    logic [31:0]  ff3_memory_addr_o;
    logic         ff3_branch_flag;
    logic [31:0]  ff3_branch_target_addr;
    logic [31:0]  ff3_link_addr;
    logic         ff3_is_in_delayslot;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         ff3_busy;
`ifdef FF3_REDIRECT_CNT_EN
    logic [31:0]  ff3_redirect_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    localparam logic [127:0] PAT_A5 = {16{8'hA5}};
    localparam logic [127:0] PAT_O  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    ff3 #(.DRAIN_CYCLES(2)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .iff3_rtaddr_e           (iff3_rtaddr_e),
        .iff3_rtaddr_o           (iff3_rtaddr_o),
        .iff3_wreg_e             (iff3_wreg_e),
        .iff3_wreg_o             (iff3_wreg_o),
        .iff3_rt_e               (iff3_rt_e),
        .iff3_rt_o               (iff3_rt_o),
        .iff3_uid_e              (iff3_uid_e),
        .iff3_uid_o              (iff3_uid_o),
        .iff3_memory_addr_o      (iff3_memory_addr_o),
        .iff3_branch_flag        (iff3_branch_flag),
        .iff3_branch_target_addr (iff3_branch_target_addr),
        .iff3_link_addr          (iff3_link_addr),
        .iff3_is_in_delayslot    (iff3_is_in_delayslot),
        .ff3_rtaddr_e            (ff3_rtaddr_e),
        .ff3_rtaddr_o            (ff3_rtaddr_o),
        .ff3_wreg_e              (ff3_wreg_e),
        .ff3_wreg_o              (ff3_wreg_o),
        .ff3_rt_e                (ff3_rt_e),
        .ff3_rt_o                (ff3_rt_o),
        .ff3_uid_e               (ff3_uid_e),
        .ff3_uid_o               (ff3_uid_o),
        .ff3_memory_addr_o       (ff3_memory_addr_o),
        .ff3_branch_flag         (ff3_branch_flag),
        .ff3_branch_target_addr  (ff3_branch_target_addr),
        .ff3_link_addr           (ff3_link_addr),
        .ff3_is_in_delayslot     (ff3_is_in_delayslot),
        .redirect_valid          (redirect_valid),
        .redirect_pc             (redirect_pc),
`ifdef FF3_REDIRECT_CNT_EN
        .ff3_redirect_cnt        (ff3_redirect_cnt),
`endif
        .ff3_busy                (ff3_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic f, input logic br, input logic ds,
                                 input logic we, input logic wo, input logic [127:0] rte);
        stall                = s;
        flush                = f;
        iff3_branch_flag     = br;
        iff3_is_in_delayslot = ds;
        iff3_wreg_e          = we;
        iff3_wreg_o          = wo;
        iff3_rt_e            = rte;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset with every input busy so that clearing is visible.
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, PAT_A5);
        iff3_rtaddr_e = 7'h7F; iff3_rtaddr_o = 7'h7F;
        iff3_rt_o = PAT_O; iff3_uid_e = 3'h7; iff3_uid_o = 3'h7;
        iff3_memory_addr_o = 32'hFFFF_FFFF;
        iff3_branch_target_addr = 32'h0000_0100;
        iff3_link_addr = 32'h0000_2008;
        tick();
        tick();
        checkOutput("reset_rt_e", ff3_rt_e, 128'h0);
        checkOutput("reset_wreg_e", ff3_wreg_e, 1'b0);
        checkOutput("reset_mem", ff3_memory_addr_o, 32'h0);
        checkOutput("reset_flag", ff3_branch_flag, 1'b0);
        checkOutput("reset_target", ff3_branch_target_addr, 32'h0);
        checkOutput("reset_valid", redirect_valid, 1'b0);
        checkOutput("reset_pc", redirect_pc, 32'h0);
        checkOutput("reset_busy", ff3_busy, 1'b0);

        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, PAT_A5);
        iff3_rtaddr_e = 7'd5; iff3_uid_e = 3'd3;
        iff3_rtaddr_o = 7'd9; iff3_uid_o = 3'd6;
        iff3_memory_addr_o = 32'hDEAD_BEEF;
        tick();
        checkOutput("cap_rt_e", ff3_rt_e, PAT_A5);
        checkOutput("cap_wreg_e", ff3_wreg_e, 1'b1);
        checkOutput("cap_rtaddr_e", ff3_rtaddr_e, 7'd5);
        checkOutput("cap_uid_e", ff3_uid_e, 3'd3);
        checkOutput("cap_rt_o", ff3_rt_o, PAT_O);
        checkOutput("cap_rtaddr_o", ff3_rtaddr_o, 7'd9);
        checkOutput("cap_uid_o", ff3_uid_o, 3'd6);
        checkOutput("cap_wreg_o", ff3_wreg_o, 1'b1);
        checkOutput("cap_mem", ff3_memory_addr_o, 32'hDEAD_BEEF);
        checkOutput("cap_link", ff3_link_addr, 32'h0000_2008);
        checkOutput("cap_busy", ff3_busy, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 128'h1234);
        tick();
        checkOutput("stall_rt_e", ff3_rt_e, PAT_A5);
        checkOutput("stall_wreg_e", ff3_wreg_e, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 128'h1234);
        tick();
        checkOutput("unstall_rt_e", ff3_rt_e, 128'h1234);
        checkOutput("unstall_wreg_e", ff3_wreg_e, 1'b0);

        // Branch, delay slot, two squashed accepted cycles around a 3-cycle stall, then pass.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 128'hB0);
        tick();
        checkOutput("br_valid", redirect_valid, 1'b1);
        checkOutput("br_pc", redirect_pc, 32'h0000_0100);
        checkOutput("br_busy", ff3_busy, 1'b1);
        checkOutput("br_flag", ff3_branch_flag, 1'b1);
        checkOutput("br_wreg_e", ff3_wreg_e, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 128'hD5);
        tick();
        checkOutput("ds_wreg_o", ff3_wreg_o, 1'b1);
        checkOutput("ds_valid", redirect_valid, 1'b0);
        checkOutput("ds_busy", ff3_busy, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 128'hC1);
        tick();
        checkOutput("sq1_wreg_e", ff3_wreg_e, 1'b0);
        checkOutput("sq1_wreg_o", ff3_wreg_o, 1'b0);
        checkOutput("sq1_rt_e", ff3_rt_e, 128'hC1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 128'hC2);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("drain_stall_rt_e", ff3_rt_e, 128'hC1);
            checkOutput("drain_stall_wreg_e", ff3_wreg_e, 1'b0);
            checkOutput("drain_stall_busy", ff3_busy, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 128'hC3);
        tick();
        checkOutput("sq2_wreg_e", ff3_wreg_e, 1'b0);
        checkOutput("sq2_flag", ff3_branch_flag, 1'b0);
        checkOutput("sq2_rt_e", ff3_rt_e, 128'hC3);
        checkOutput("sq2_busy", ff3_busy, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 128'hC4);
        tick();
        checkOutput("pass_wreg_e", ff3_wreg_e, 1'b1);
        checkOutput("pass_wreg_o", ff3_wreg_o, 1'b1);
        checkOutput("pass_valid", redirect_valid, 1'b0);

        // Delay-slot instruction inside the drain window.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 128'hE0);
        tick();
        checkOutput("dsd_valid", redirect_valid, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 128'hE1);
        tick();
        checkOutput("redir_cap_wreg_e", ff3_wreg_e, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 128'hE2);
        tick();
        checkOutput("dsd_pass_wreg_e", ff3_wreg_e, 1'b1);
        checkOutput("dsd_pass_busy", ff3_busy, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 128'hE3);
        tick();
        checkOutput("dsd_sq_wreg_e", ff3_wreg_e, 1'b0);
        checkOutput("dsd_busy", ff3_busy, 1'b0);

        // Stall during REDIRECT still moves on to DRAIN.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 128'hF0);
        tick();
        checkOutput("rs_valid", redirect_valid, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 128'hF1);
        tick();
        checkOutput("rs_valid_after", redirect_valid, 1'b0);
        checkOutput("rs_busy", ff3_busy, 1'b1);
        checkOutput("rs_rt_e", ff3_rt_e, 128'hF0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 128'hF2);
        tick();
        checkOutput("rs_sq1_wreg_e", ff3_wreg_e, 1'b0);
        tick();
        checkOutput("rs_sq2_wreg_e", ff3_wreg_e, 1'b0);
        checkOutput("rs_sq2_busy", ff3_busy, 1'b0);
        tick();
        checkOutput("rs_pass_wreg_e", ff3_wreg_e, 1'b1);

        // Flush together with a new branch while in REDIRECT.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 128'h10);
        tick();
        checkOutput("fl_valid_pre", redirect_valid, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 128'h11);
        #1;
        checkOutput("fl_valid", redirect_valid, 1'b0);
        checkOutput("fl_pc", redirect_pc, 32'h0);
        tick();
        checkOutput("fl_busy", ff3_busy, 1'b0);
        checkOutput("fl_wreg_e", ff3_wreg_e, 1'b0);
        checkOutput("fl_wreg_o", ff3_wreg_o, 1'b0);
        checkOutput("fl_flag", ff3_branch_flag, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 128'h12);
        tick();
        checkOutput("fl_after_valid", redirect_valid, 1'b0);
        checkOutput("fl_after_busy", ff3_busy, 1'b0);
        checkOutput("fl_after_wreg_e", ff3_wreg_e, 1'b1);

        // Reset in the middle of a drain.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 128'h20);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 128'h21);
        tick();
        checkOutput("mid_busy", ff3_busy, 1'b1);
        rst = 1'b1;
        tick();
        checkOutput("rst_busy", ff3_busy, 1'b0);
        checkOutput("rst_valid", redirect_valid, 1'b0);
        checkOutput("rst_rt_e", ff3_rt_e, 128'h0);
        checkOutput("rst_wreg_e", ff3_wreg_e, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 128'h22);
        tick();
        checkOutput("rst_after_wreg_e", ff3_wreg_e, 1'b1);
        checkOutput("rst_after_valid", redirect_valid, 1'b0);
        checkOutput("rst_after_busy", ff3_busy, 1'b0);

        // Three complete redirect sequences.
        for (int r = 0; r < 3; r++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 128'h30);
            tick();
            checkOutput("loop_valid", redirect_valid, 1'b1);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 128'h31);
            tick();
            tick();
            tick();
            checkOutput("loop_busy", ff3_busy, 1'b0);
        end
`ifdef FF3_REDIRECT_CNT_EN
        checkOutput("redirect_cnt", ff3_redirect_cnt, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
